// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; a push lands on the head one cycle later, with no write-through.
// Backpressure: a write into a full FIFO is dropped unless a pop happens in the same cycle; a drop gives a one-cycle overflow_o pulse.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_en_o,
  input  logic                  tx_rdy_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow_q;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign full_o     = (count == CNT_FULL);
  assign empty_o    = (count == '0);
  assign count_o    = count;
  assign overflow_o = overflow_q;
  assign tx_en_o    = ~empty_o;
  assign tx_data_o  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a write against a full FIFO still lands.
  assign pop  = tx_en_o & tx_rdy_i;
  assign push = wr_en_i & (~full_o | pop);
  assign drop = wr_en_i & full_o & ~pop;

  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      overflow_q <= drop;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random stimulus for uart_tx_fifo, checked against a queue-based model of the FIFO.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic       wr_en_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       tx_rdy_i = 1'b0;
  logic       full_o;
  logic       empty_o;
  logic [4:0] count_o;
  logic       overflow_o;
  logic [7:0] tx_data_o;
  logic       tx_en_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q[$];
  logic [7:0] rx[$];
  bit         m_ovf = 1'b0;

  uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data_i  (wr_data_i),
    .wr_en_i    (wr_en_i),
    .flush_i    (flush_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .tx_data_o  (tx_data_o),
    .tx_en_o    (tx_en_o),
    .tx_rdy_i   (tx_rdy_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count_o), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty_o), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full_o),  32'(q.size() == 16));
    chk({tag, ".tx_en"}, 32'(tx_en_o), 32'(q.size() != 0));
    chk({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
    if (q.size() != 0) chk({tag, ".head"}, 32'(tx_data_o), 32'(q[0]));
  endtask

  // Reference behaviour: queue with capacity 16; a pop frees room for a same-cycle write.
  task automatic model_step(input bit we, input logic [7:0] d, input bit rdy, input bit fl);
    bit was_full;
    bit p;
    was_full = (q.size() == 16);
    p = rdy && (q.size() != 0);
    if (p) rx.push_back(q[0]);
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (p) void'(q.pop_front());
      if (we && (!was_full || p)) q.push_back(d);
      m_ovf = we && was_full && !p;
    end
  endtask

  task automatic cyc(input bit we, input logic [7:0] d, input bit rdy, input bit fl, input string tag);
    wr_en_i   = we;
    wr_data_i = d;
    tx_rdy_i  = rdy;
    flush_i   = fl;
    model_step(we, d, rdy, fl);
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, ".rst_empty"}, 32'(empty_o), 32'd1);
    chk({tag, ".rst_full"},  32'(full_o),  32'd0);
    chk({tag, ".rst_count"}, 32'(count_o), 32'd0);
    chk({tag, ".rst_tx_en"}, 32'(tx_en_o), 32'd0);
    chk({tag, ".rst_ovf"},   32'(overflow_o), 32'd0);
    q.delete();
    m_ovf = 1'b0;
    #3 rst = 1'b0;
  endtask

  initial begin
    int sent;
    int budget;
    logic [7:0] b;

    // Reset asserted mid-cycle, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("reset.empty", 32'(empty_o), 32'd1);
    chk("reset.full",  32'(full_o),  32'd0);
    chk("reset.count", 32'(count_o), 32'd0);
    chk("reset.tx_en", 32'(tx_en_o), 32'd0);
    chk("reset.ovf",   32'(overflow_o), 32'd0);
    #8 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single byte with the transmitter always ready.
    cyc(1'b1, 8'hA5, 1'b1, 1'b0, "single.push");
    chk("single.data", 32'(tx_data_o), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "single.pop");
    chk("single.empty_after", 32'(empty_o), 32'd1);

    // Fill past capacity.
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    chk("fill.count16", 32'(count_o), 32'd16);
    chk("fill.ovf_pulse", 32'(overflow_o), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, "fill.idle");
    chk("fill.ovf_gone", 32'(overflow_o), 32'd0);

    // Drain with single-cycle ready pulses.
    rx.delete();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, "drain.pop");
      cyc(1'b0, 8'h00, 1'b0, 1'b0, "drain.gap");
    end
    for (int i = 0; i < 16; i++) chk("drain.order", 32'(rx[i]), 32'(i));

    // Write and pop together while full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "refill");
    b = q[1];
    cyc(1'b1, 8'h55, 1'b1, 1'b0, "fullwp");
    chk("fullwp.count", 32'(count_o), 32'd16);
    chk("fullwp.no_ovf", 32'(overflow_o), 32'd0);
    chk("fullwp.head_adv", 32'(tx_data_o), 32'(b));
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "fullwp.flush");

    // Wrap-around stream against a slow transmitter.
    rx.delete();
    sent = 0;
    budget = 0;
    while (rx.size() < 40 && budget < 2000) begin
      bit we;
      we = (sent < 40) && (q.size() < 16) && ($urandom_range(0, 1) == 1);
      cyc(we, 8'(sent), (budget % 10) == 9, 1'b0, "wrap");
      if (we) sent++;
      budget++;
    end
    chk("wrap.received", 32'(rx.size()), 32'd40);
    for (int i = 0; i < 40 && i < rx.size(); i++) chk("wrap.order", 32'(rx[i]), 32'(i));

    // Flush mid-operation, with a competing write and pop.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, "preflush");
    cyc(1'b1, 8'h99, 1'b1, 1'b1, "flush");
    chk("flush.count", 32'(count_o), 32'd0);
    chk("flush.tx_en", 32'(tx_en_o), 32'd0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, "flush.newhead");
    chk("flush.head3c", 32'(tx_data_o), 32'h3C);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "flush.clear");

    // Same with an asynchronous reset.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "prerst");
    async_reset("midrst");
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, "rst.newhead");
    chk("rst.head3c", 32'(tx_data_o), 32'h3C);
    chk("rst.count1", 32'(count_o), 32'd1);

    // Random traffic including occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
          $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO sitting directly upstream of the UART transmitter. It buffers bytes written by the host logic and presents them to the transmitter's `tx_data_i` / `tx_en_i` / `tx_rdy_o` handshake, one byte per accepted transfer. It lets bursts be written at clock rate while the transmitter drains at baud rate.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: width of each byte entry.
- `DEPTH_LOG2`, default 4: log2 of the FIFO depth (default depth 16 entries).

**Ports**
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: reset, asynchronous and active-high.
- `wr_data_i`, input, DATA_WIDTH: byte to enqueue.
- `wr_en_i`, input, 1: enqueue request, one byte per cycle while high.
- `flush_i`, input, 1: synchronous clear of all contents.
- `full_o`, output, 1: FIFO holds 2^DEPTH_LOG2 entries.
- `empty_o`, output, 1: FIFO holds 0 entries.
- `count_o`, output, DEPTH_LOG2+1: current occupancy.
- `overflow_o`, output, 1: one-cycle pulse when a write is dropped.
- `tx_data_o`, output, DATA_WIDTH: head entry; connects to transmitter `tx_data_i`.
- `tx_en_o`, output, 1: head valid; connects to transmitter `tx_en_i`.
- `tx_rdy_i`, input, 1: transmitter ready; connects to transmitter `tx_rdy_o`.

## Operation

**Storage**
- Register array of 2^DEPTH_LOG2 × DATA_WIDTH. The array is not reset.
- `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits each and wrap modulo depth.
- `count` is DEPTH_LOG2+1 bits.

**Status flags**
- `full_o = (count == 2^DEPTH_LOG2)`.
- `empty_o = (count == 0)`.
- `count_o = count`.
- All three are derived from registered state only.

**Pop (drain to transmitter)**
- `pop = tx_en_o & tx_rdy_i`. This is the same condition under which the transmitter latches the byte.
- On pop, `rd_ptr` increments.

**Write acceptance**
- `push = wr_en_i & (!full_o | pop)`. A write into a full FIFO in the same cycle as a pop is accepted.
- On push, `mem[wr_ptr] <= wr_data_i` and `wr_ptr` increments.
- `wr_en_i & full_o & !pop` drops the byte. State is unchanged and `overflow_o` is 1 on the next cycle (registered pulse).

**Count update**
- push only: count+1.
- pop only: count−1.
- push and pop together: count unchanged.
- No underflow or overflow of `count` is possible.

**Head outputs**
- `tx_en_o = !empty_o`.
- `tx_data_o = mem[rd_ptr]`. It is stable for as long as `tx_en_o` is high and no pop has occurred.

**Flush**
- `flush_i` high at a clock edge sets both pointers and `count` to 0 and clears `overflow_o`.
- Flush has priority over push and pop in that cycle.
- The transmitter may already have latched a byte in the flush cycle, if `pop` was true. That byte still goes out; nothing else is recalled.

**Reset**
- Asynchronous assertion immediately forces pointers = 0, `count` = 0 and `overflow_o` = 0.
- So during and after reset: `empty_o` = 1, `full_o` = 0, `count_o` = 0, `tx_en_o` = 0, `overflow_o` = 0.
- `tx_data_o` is undefined after reset (array not reset).
- Reset mid-burst discards all contents. Deassertion is synchronous to `clk` at the instantiating level.

## Timing

**Latency**
- A byte pushed at edge N into an empty FIFO gives `tx_en_o` = 1 with that byte on `tx_data_o` after edge N. It is available to the transmitter in cycle N+1.
- There is no write-through in the push cycle.

**Throughput**
- One push per cycle.
- One pop per cycle when `tx_rdy_i` allows. The transmitter drops `tx_rdy_i` the cycle after it accepts, so in practice pops are spaced by one frame.

**Handshake stability**
- `tx_en_o` never deasserts without a pop, except on flush or reset.
- `tx_data_o` changes only after a pop, or when the first write lands in an empty FIFO.

**Other timing**
- `overflow_o` is high for exactly one cycle per dropped byte. Consecutive drops give consecutive high cycles.
- Pointer wrap from 2^DEPTH_LOG2−1 to 0 is seamless. `count` alone distinguishes full from empty.

## Test plan

- **Reset values:** assert `rst` asynchronously mid-cycle -> `empty_o`=1, `full_o`=0, `count_o`=0, `tx_en_o`=0, `overflow_o`=0, immediately and without waiting for a `clk` edge.
- **Single byte:** with `tx_rdy_i`=1, write 0xA5 -> `tx_en_o`=1 and `tx_data_o`=0xA5 the next cycle. Pop occurs that cycle, then `empty_o` returns to 1 and `count_o` to 0.
- **Fill and overflow:** with `tx_rdy_i`=0, write 17 bytes 0x00..0x10 -> `full_o` after the 16th and `count_o`=16. 0x10 is dropped and `overflow_o` pulses once. Then with `tx_rdy_i` pulsed, bytes drain 0x00..0x0F in order.
- **Write and pop while full:** with `full_o`=1, assert `wr_en_i`=1 (0x55) and `tx_rdy_i`=1 in the same cycle -> 0x55 is accepted, `count_o` stays 16, no overflow, head advances by one.
- **Wrap-around:** stream 40 bytes 0x00..0x27 against a model transmitter (ready 1 cycle in every 10) with writes never exceeding space -> all 40 bytes are received in order, `overflow_o` never asserts, and `count_o` matches the model every cycle.
- **Flush and reset mid-operation:** with 5 entries, assert `flush_i` one cycle -> `count_o`=0 and `tx_en_o`=0 next cycle, and a subsequent write of 0x3C is the new head. Repeat with async `rst` in place of `flush_i` -> same result.
